// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Starvation counter is never narrower than 3 bits.
    function automatic int cnt_width(input int max_val);
        return ($clog2(max_val + 1) < 3) ? 3 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-requester pick; winner bit index equals owner ID
module dmem_arb_pick (
    input  logic       c_req,
    input  logic       h_req,
    input  logic       host_first,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        if (h_req && (host_first || !c_req)) begin
            winner = 2'b10;
        end else if (c_req) begin
            winner = 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host data-memory arbiter; DMEM_ARB_RR_EN selects round-robin
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t        state_q;
    state_t        state_d;
    owner_t        owner_q;
    logic [1:0]    winner;
    logic          host_first;
    logic          take;
    logic          pick_host;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] h_rdata_q;

    assign take      = (state_q == IDLE) && (c_req || h_req);
    assign pick_host = winner[1];

    dmem_arb_pick u_pick (
        .c_req      (c_req),
        .h_req      (h_req),
        .host_first (host_first),
        .winner     (winner)
    );

`ifdef DMEM_ARB_RR_EN
    logic rr_host;

    // After a core grant the host is favoured on the next tie, and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_host <= 1'b0;
        end else if (take) begin
            rr_host <= winner[0];
        end
    end

    assign host_first = rr_host;
`else
    localparam int CW = cnt_width(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state_q == IDLE) begin
            if (!h_req || pick_host) begin
                starve_cnt <= '0;
            end else if (c_req && (starve_cnt < CW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    assign host_first = (starve_cnt >= CW'(STARVE_MAX));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        c_gnt    = 1'b0;
        h_gnt    = 1'b0;
        c_rvalid = 1'b0;
        h_rvalid = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (c_req || h_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                c_gnt   = (owner_q == OWN_CORE);
                h_gnt   = (owner_q == OWN_HOST);
                state_d = mem_we ? IDLE : RESP;
            end
            RESP: begin
                c_rvalid = (owner_q == OWN_CORE);
                h_rvalid = (owner_q == OWN_HOST);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The memory command registers double as the authoritative latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner_q   <= OWN_CORE;
        end else begin
            mem_en <= take;
            mem_we <= take && (pick_host ? h_we : c_we);
            if (take) begin
                owner_q   <= pick_host ? OWN_HOST : OWN_CORE;
                mem_addr  <= pick_host ? h_addr : c_addr;
                mem_wdata <= pick_host ? h_wdata : c_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            if (c_rvalid) begin
                c_rdata_q <= mem_rdata;
            end
            if (h_rvalid) begin
                h_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data is forwarded during the response cycle, then held.
    assign c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
    assign h_rdata = h_rvalid ? mem_rdata : h_rdata_q;
    assign c_stall = c_req && !c_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (either DMEM_ARB_RR_EN setting)
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        c_req, c_we, c_gnt, c_rvalid, c_stall;
    logic [7:0]  c_addr;
    logic [15:0] c_wdata, c_rdata;
    logic        h_req, h_we, h_gnt, h_rvalid;
    logic [7:0]  h_addr;
    logic [15:0] h_wdata, h_rdata;
    logic        mem_en, mem_we, busy;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    typedef struct {
        bit          host;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          gcyc;
    } txn_t;

    txn_t        sb[$];
    txn_t        rdq[$];
    int          rd_cyc[$];
    logic [15:0] mem_model [256];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [9:0]  order;

    dmem_arbiter #(.AW(8), .DW(16), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .c_stall   (c_stall),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears one cycle after the read command.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= {8'hA5, 8'(i)};
            mem_model[3] <= 16'd123;
            mem_rdata    <= '0;
        end else begin
            if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input bit host, input bit we, input logic [7:0] a,
                                input logic [15:0] d, input logic [15:0] r, input int g);
        txn_t t;
        t.host = host; t.we = we; t.addr = a; t.wdata = d; t.rdata = r; t.gcyc = g;
        return t;
    endfunction

    task automatic mon();
        txn_t t;
        int   rc;
        if (rst_n) begin
            if (c_req) chk("c_stall", 32'(c_stall), 32'(!c_gnt));
            if (c_gnt || h_gnt) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", 32'({h_gnt, c_gnt}), 32'(0));
                end else begin
                    t = sb.pop_front();
                    chk("gnt_owner", 32'({h_gnt, c_gnt}), t.host ? 32'd2 : 32'd1);
                    if (t.gcyc >= 0) chk("gnt_cycle", 32'(cyc), 32'(t.gcyc));
                    chk("mem_en", 32'(mem_en), 32'(1));
                    chk("mem_we", 32'(mem_we), 32'(t.we));
                    chk("mem_addr", 32'(mem_addr), 32'(t.addr));
                    if (t.we) chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
                    else begin
                        rdq.push_back(t);
                        rd_cyc.push_back(cyc + 1);
                    end
                end
            end else begin
                chk("mem_idle", 32'({mem_en, mem_we}), 32'(0));
            end
            if (c_rvalid || h_rvalid) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_rvalid", 32'({h_rvalid, c_rvalid}), 32'(0));
                end else begin
                    t  = rdq.pop_front();
                    rc = rd_cyc.pop_front();
                    chk("rvalid_owner", 32'({h_rvalid, c_rvalid}), t.host ? 32'd2 : 32'd1);
                    chk("rvalid_cycle", 32'(cyc), 32'(rc));
                    chk("rdata", 32'(t.host ? h_rdata : c_rdata), 32'(t.rdata));
                end
            end
        end
    endtask

    task automatic half_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic half_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half_neg();
        half_pos();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            step();
            if (!busy && rdq.size() == 0) break;
        end
        chk("idle_reached", 32'({busy, rdq.size() != 0}), 32'(0));
    endtask

    task automatic run_one(input bit host, input bit we, input logic [7:0] a,
                           input logic [15:0] d, input logic [15:0] r);
        sb.push_back(mk(host, we, a, d, r, cyc + 1));
        if (host) begin
            h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (sb.size() == 0) break;
        end
        chk("gnt_seen", 32'(sb.size()), 32'(0));
        c_req = 1'b0;
        h_req = 1'b0;
        if (we) chk("write_back_idle", 32'(busy), 32'(0));
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DMEM_ARB_RR_EN
        order = 10'b1010101010;
`else
        order = 10'b1000010000;
`endif
        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({busy, mem_en, mem_we, c_gnt, h_gnt, c_rvalid, h_rvalid}), 32'(0));
        chk("rst_rdata", 32'({c_rdata, h_rdata}), 32'(0));
        chk("rst_mem_cmd", 32'({mem_addr, mem_wdata}), 32'(0));
        rst_n = 1'b1;

        run_one(1'b0, 1'b0, 8'h03, 16'h0000, 16'd123);
        run_one(1'b1, 1'b1, 8'h36, 16'h00AA, 16'h0000);
        run_one(1'b1, 1'b0, 8'h36, 16'h0000, 16'h00AA);
        chk("c_rdata_hold", 32'(c_rdata), 32'd123);

        // Payload changes after the sampling edge must be ignored.
        sb.push_back(mk(1'b0, 1'b1, 8'h0E, 16'h1111, 16'h0, cyc + 1));
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h0E; c_wdata = 16'h1111;
        half_neg();
        half_pos();
        c_addr = 8'h2B; c_wdata = 16'h2222;
        half_neg();
        chk("latched_addr", 32'(mem_addr), 32'h0E);
        chk("latched_wdata", 32'(mem_wdata), 32'h1111);
        half_pos();
        c_req = 1'b0;
        wait_idle();
        run_one(1'b0, 1'b0, 8'h0E, 16'h0, 16'h1111);
        run_one(1'b0, 1'b0, 8'h2B, 16'h0, 16'hA52B);

        // Reset in the response cycle of a core read, host waiting.
        sb.push_back(mk(1'b0, 1'b0, 8'h05, 16'h0, 16'h0, cyc + 1));
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h05;
        step();
        step();
        c_req = 1'b0;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h40; h_wdata = 16'h4444;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({busy, mem_en, mem_we, c_gnt, h_gnt, c_rvalid, h_rvalid}), 32'(0));
        chk("rst_mid_rdata", 32'({c_rdata, h_rdata}), 32'(0));
        chk("rst_mid_mem_cmd", 32'({mem_addr, mem_wdata}), 32'(0));
        rdq.delete();
        rd_cyc.delete();
        half_neg();
        half_pos();
        rst_n = 1'b1;
        sb.push_back(mk(1'b1, 1'b1, 8'h40, 16'h4444, 16'h0, cyc + 1));
        step();
        half_neg();
        chk("post_rst_h_gnt", 32'(h_gnt), 32'(1));
        half_pos();
        h_req = 1'b0;
        wait_idle();

        // Same-address writes from both sides: serviced in turn, never merged.
        sb.push_back(mk(1'b0, 1'b1, 8'h20, 16'hAAAA, 16'h0, cyc + 1));
        sb.push_back(mk(1'b1, 1'b1, 8'h20, 16'h5555, 16'h0, -1));
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h20; c_wdata = 16'hAAAA;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h20; h_wdata = 16'h5555;
        for (int i = 0; i < 30; i++) begin
            step();
            if (sb.size() <= 1) c_req = 1'b0;
            if (sb.size() == 0) break;
        end
        h_req = 1'b0;
        chk("tie_done", 32'(sb.size()), 32'(0));
        wait_idle();
        run_one(1'b1, 1'b0, 8'h20, 16'h0, 16'h5555);

        // Both requesting continuously.
        for (int i = 0; i < 10; i++) begin
            if (order[i]) sb.push_back(mk(1'b1, 1'b1, 8'h60, 16'hBEEF, 16'h0, -1));
            else          sb.push_back(mk(1'b0, 1'b1, 8'h50, 16'hC0DE, 16'h0, -1));
        end
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h50; c_wdata = 16'hC0DE;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h60; h_wdata = 16'hBEEF;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sb.size() == 0) break;
        end
        c_req = 1'b0;
        h_req = 1'b0;
        chk("contend_done", 32'(sb.size()), 32'(0));
        wait_idle();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
